// File: rtl/integer_alu_pkg.sv
// Shared opcodes, FSM states and helpers for the
// sequential integer ALU and its mul/div engine.
package integer_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_SLL    = 5'h02,
    OP_SRL    = 5'h03,
    OP_SRA    = 5'h04,
    OP_LTU    = 5'h05,
    OP_LTS    = 5'h06,
    OP_AND    = 5'h07,
    OP_OR     = 5'h08,
    OP_XOR    = 5'h09,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

  // All M-extension codes live in 0x10..0x17.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/integer_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide on
// magnitudes, with sign fix-up when the count runs out.
module integer_muldiv_iter
  import integer_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

  logic [2*W-1:0] acc;
  logic [W-1:0]   opd;
  logic [W-1:0]   a_q;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           want_hi;
  logic           want_rem;
  logic           neg;
  logic           b_zero;

  logic           op_div;
  logic           a_sgn;
  logic           b_sgn;
  logic           sa;
  logic           sb;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [W-1:0]   lo0;
  logic [W-1:0]   d0;

  assign op_div = op[2];
  assign a_sgn  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn  = op inside {OP_MULH, OP_DIV, OP_REM};
  assign sa     = a_sgn & a[W-1];
  assign sb     = b_sgn & b[W-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;
  assign lo0    = op_div ? ma : mb;
  assign d0     = op_div ? mb : ma;

  // acc = {hi, lo}: mul keeps partial product / multiplier,
  // div keeps partial remainder / dividend-then-quotient.
  function automatic logic [2*W-1:0] step(
    input logic           div,
    input logic [2*W-1:0] acc_i,
    input logic [W-1:0]   d
  );
    logic [W:0] sum;
    logic [W:0] sh;
    logic [W:0] tr;
    sum = {1'b0, acc_i[2*W-1:W]}
        + (acc_i[0] ? {1'b0, d} : '0);
    sh  = {acc_i[2*W-1:W], acc_i[W-1]};
    tr  = sh - {1'b0, d};
    if (!div)
      step = {sum, acc_i[W-1:1]};
    else if (!tr[W])
      step = {tr[W-1:0], acc_i[W-2:0], 1'b1};
    else
      step = {sh[W-1:0], acc_i[W-2:0], 1'b0};
  endfunction

  assign done = busy & (cnt == LAST);

  // The first step happens on the start edge, so the
  // last busy cycle is free for the fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_q      <= '0;
      is_div   <= 1'b0;
      want_hi  <= 1'b0;
      want_rem <= 1'b0;
      neg      <= 1'b0;
      b_zero   <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= CW'(1);
      acc      <= step(op_div, {{W{1'b0}}, lo0}, d0);
      opd      <= d0;
      a_q      <= a;
      is_div   <= op_div;
      want_hi  <= op[1:0] != 2'b00;
      want_rem <= op[1];
      neg      <= (op_div & op[1]) ? sa : sa ^ sb;
      b_zero   <= b == '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        acc <= step(is_div, acc, opd);
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   q;
  logic [W-1:0]   r;

  always_comb begin
    prod   = neg ? -acc : acc;
    q      = neg ? -acc[W-1:0] : acc[W-1:0];
    r      = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    result = '0;
    if (!is_div)
      result = want_hi ? prod[2*W-1:W] : prod[W-1:0];
    else if (b_zero)
      result = want_rem ? a_q : '1;
    else
      result = want_rem ? r : q;
  end

endmodule

// File: rtl/integer_seq_alu.sv
// Handshaked integer ALU: one op in flight, registered
// result, single-cycle base ops, iterative mul/div.
module integer_seq_alu
  import integer_alu_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_illegal
);

  alu_state_e state;

  logic [DATA_WIDTH-1:0]  basic_res;
  logic                   basic_ill;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   md_start;
  logic                   md_busy;
  logic                   md_done;
  logic [DATA_WIDTH-1:0]  md_result;

  assign shamt = B[SHAMT_WIDTH-1:0];

  always_comb begin
    basic_res = '0;
    basic_ill = 1'b0;
    unique case (alu_op)
      OP_ADD: basic_res = A + B;
      OP_SUB: basic_res = A - B;
      OP_SLL: basic_res = A << shamt;
      OP_SRL: basic_res = A >> shamt;
      OP_SRA: basic_res = $signed(A) >>> shamt;
      OP_LTU: basic_res = {{(DATA_WIDTH-1){1'b0}}, A < B};
      OP_LTS: basic_res = {{(DATA_WIDTH-1){1'b0}},
                           $signed(A) < $signed(B)};
      OP_AND: basic_res = A & B;
      OP_OR:  basic_res = A | B;
      OP_XOR: basic_res = A ^ B;
      default: basic_ill = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE) & ~md_busy;
  assign out_valid = state == DONE;
  assign md_start  = in_ready & in_valid & ~flush
                   & is_muldiv(alu_op);

  integer_muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset | flush),
    .start (md_start),
    .op    (alu_op),
    .a     (A),
    .b     (B),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_result)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state       <= IDLE;
      out         <= '0;
      out_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (is_muldiv(alu_op)) begin
              state <= BUSY;
            end else begin
              state       <= DONE;
              out         <= basic_res;
              out_illegal <= basic_ill;
            end
          end
        end
        BUSY: begin
          if (md_done) begin
            state <= DONE;
            out   <= md_result;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out         <= '0;
            out_illegal <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
